regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-back scheduler for the 32-entry integer register file. It shares the file's single write port between three write-back requesters: ALU (port 0), load/store unit (port 1) and mul/div unit (port 2). It also keeps a per-register in-flight scoreboard, which the issue stage uses for RAW hazard stalls. The block sits between the execute units and the register file; its registered outputs drive the file's write inputs directly.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (fixed at 3; not generic).
- CNTW, 2, width of each per-register in-flight counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid_i  in  3  per-requester write request.
- wb_rd_i  in  3x5  per-requester destination register.
- wb_data_i  in  3x32  per-requester write data.
- wb_pos_i  in  3x4  per-requester 4-bit position tag.
- wb_ready_o  out  3  grant; a transfer completes when valid and ready are both 1 in the same cycle.
- issue_valid_i  in  1  issue stage dispatches an instruction that writes issue_rd_i.
- issue_rd_i  in  5  destination of the dispatched instruction.
- issue_ready_o  out  1  0 when the counter for issue_rd_i is saturated.
- RSaddr_i, RTaddr_i  in  5 each  source registers to check.
- rs_busy_o, rt_busy_o  out  1 each  source has a nonzero in-flight count.
- RegWrite_o  out  1  write enable to the register file.
- RDaddr_o  out  5  write address.
- RDdata_o  out  32  write data.
- is_pos_o  out  4  position tag to the register file.

## Operation
- Arbitration is round-robin over valid requesters.
  - rr_ptr (2 bits) holds the last granted port.
  - Search order is rr_ptr+1, rr_ptr+2, rr_ptr+3, modulo 3.
  - rr_ptr updates only when a grant occurs.
- wb_ready_o is combinational. At most one bit is set, and only for a valid requester.
- Requesters hold valid, rd, data and pos stable until granted.
- A granted transfer is registered into RegWrite_o, RDaddr_o, RDdata_o and is_pos_o on the next rising edge.
- If no grant occurs, RegWrite_o=0 on that edge and the other outputs hold their previous values.
- Writes to x0:
  - The requester is still granted, and the grant still advances rr_ptr.
  - RegWrite_o stays 0 for that write.
- Scoreboard: cnt[r] is a CNTW-bit count of in-flight writes per register, r=1..31. cnt[0] is always 0.
  - An accepted issue (issue_valid_i & issue_ready_o, rd≠0) increments cnt[issue_rd_i].
  - A granted write-back with rd≠0 decrements cnt[wb_rd].
  - An increment and a decrement to the same register in the same cycle leave it unchanged.
  - issue_ready_o = (cnt[issue_rd_i] != 2^CNTW−1). issue_ready_o is always 1 for rd=0.
  - A decrement of a counter already at 0 is a protocol error. The counter stays 0 (no underflow) and the event is flagged in simulation by an assertion.
- Busy flags:
  - rs_busy_o = (cnt[RSaddr_i] != 0); rt_busy_o likewise.
  - Both are combinational from current state. A same-cycle write-back does not clear them until the next cycle.

## Timing
- Reset (reset_n=0, asynchronous):
  - RegWrite_o=0, RDaddr_o=0, RDdata_o=0, is_pos_o=0.
  - All cnt=0, rr_ptr=2, so port 0 wins first.
  - wb_ready_o=0 while reset is asserted.
- Latency: grant cycle N → RegWrite_o high during cycle N+1.
  - The register file samples on the falling edge inside cycle N+1, so data is readable from cycle N+2.
  - cnt decrements at the edge ending cycle N, so busy drops in cycle N+1.
- Throughput: one write-back per cycle.
- With all three requesters continuously valid, each is granted once every 3 cycles.
- Reset asserted mid-transfer:
  - Outputs clear immediately.
  - Any in-flight grant is discarded.
  - Requesters re-present their writes after reset.

## Test plan
- Reset: hold reset_n=0 with all inputs active → RegWrite_o=0, wb_ready_o=000, rs_busy_o=0. Release → first grant with valid=111 goes to port 0.
- Round-robin: valid=111 held for 6 cycles → grants 0,1,2,0,1,2. Each grant appears on RegWrite_o/RDaddr_o one cycle later with matching data and pos.
- Scoreboard: issue rd=5 three times → issue_ready_o=0 for rd=5, rs_busy_o=1 for RSaddr_i=5. Three write-backs to rd=5 → busy clears the cycle after the third grant.
- Simultaneous: issue rd=7 and grant write-back rd=7 in the same cycle with cnt[7]=1 → cnt[7] stays 1 and rt_busy_o stays 1.
- x0: port 1 writes rd=0, data 0xDEADBEEF → wb_ready_o[1]=1, RegWrite_o stays 0, rr_ptr advances to 1.
- Mid-operation reset: assert reset_n=0 while RegWrite_o=1 → RegWrite_o drops with no clock edge, and all counters read 0 after release.

Source files
------------

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the 32-entry integer register file.
// Three execute units share the file's single write port through a
// round-robin arbiter. A per-register in-flight counter gives the issue
// stage its RAW hazard view. Grants are registered straight onto the
// register file write inputs.
module regfile_wb_sched #(
    parameter int NREQ = 3,
    parameter int CNTW = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n,

    input  logic [NREQ-1:0]       wb_valid_i,
    input  logic [NREQ-1:0][4:0]  wb_rd_i,
    input  logic [NREQ-1:0][31:0] wb_data_i,
    input  logic [NREQ-1:0][3:0]  wb_pos_i,
    output logic [NREQ-1:0]       wb_ready_o,

    input  logic                  issue_valid_i,
    input  logic [4:0]            issue_rd_i,
    output logic                  issue_ready_o,

    input  logic [4:0]            RSaddr_i,
    input  logic [4:0]            RTaddr_i,
    output logic                  rs_busy_o,
    output logic                  rt_busy_o,

    output logic                  RegWrite_o,
    output logic [4:0]            RDaddr_o,
    output logic [31:0]           RDdata_o,
    output logic [3:0]            is_pos_o
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    // Round-robin pointer holds the most recently granted port.
    logic [1:0]      rr_ptr_q, rr_ptr_d;

    logic            gnt_any;
    logic [1:0]      gnt_idx;
    logic [1:0]      cand;
    logic [4:0]      sel_rd;
    logic [31:0]     sel_data;
    logic [3:0]      sel_pos;

    logic            regwrite_q, regwrite_d;
    logic [4:0]      rdaddr_q, rdaddr_d;
    logic [31:0]     rddata_q, rddata_d;
    logic [3:0]      pos_q, pos_d;

    logic [CNTW-1:0] cnt_q [32];
    logic [CNTW-1:0] cnt_d [32];

    logic            inc_en;
    logic            dec_en;
    logic            underflow;

    // Pick the first valid requester after the last granted one (wrapping
    // modulo 3); nothing is granted while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        cand    = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand >= 2'd2) ? 2'd0 : cand + 2'd1;
            if (!gnt_any && wb_valid_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (!reset_n) begin
            gnt_any = 1'b0;
        end
    end

    assign wb_ready_o = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    assign sel_rd     = wb_rd_i[gnt_idx];
    assign sel_data   = wb_data_i[gnt_idx];
    assign sel_pos    = wb_pos_i[gnt_idx];

    // Next write-port contents; x0 writes are granted but never enabled,
    // and the address/data/pos hold whenever no real write goes out.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        regwrite_d = 1'b0;
        rdaddr_d   = rdaddr_q;
        rddata_d   = rddata_q;
        pos_d      = pos_q;
        if (gnt_any) begin
            rr_ptr_d = gnt_idx;
            if (sel_rd != 5'd0) begin
                regwrite_d = 1'b1;
                rdaddr_d   = sel_rd;
                rddata_d   = sel_data;
                pos_d      = sel_pos;
            end
        end
    end

    // Issue is only refused when its destination counter is saturated.
    assign issue_ready_o = (issue_rd_i == 5'd0) || (cnt_q[issue_rd_i] != CNT_MAX);
    assign inc_en        = issue_valid_i && issue_ready_o && (issue_rd_i != 5'd0);
    assign dec_en        = gnt_any && (sel_rd != 5'd0);

    // In-flight counters: a matching increment and decrement cancel, and a
    // decrement of an empty counter is clamped at zero and flagged.
    always_comb begin
        underflow = 1'b0;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < 32; r++) begin
            if (inc_en && (issue_rd_i == 5'(r)) && !(dec_en && (sel_rd == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNTW'(1);
            end else if (dec_en && (sel_rd == 5'(r)) && !(inc_en && (issue_rd_i == 5'(r)))) begin
                if (cnt_q[r] == '0) begin
                    underflow = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNTW'(1);
                end
            end
        end
        cnt_d[0] = '0;
    end

    // Busy reflects the registered counters, so a write-back granted this
    // cycle only clears busy from the next cycle on.
    assign rs_busy_o = (cnt_q[RSaddr_i] != '0);
    assign rt_busy_o = (cnt_q[RTaddr_i] != '0);

    // State registers; reset points rr_ptr at port 2 so port 0 wins first.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= 2'd2;
            regwrite_q <= 1'b0;
            rdaddr_q   <= 5'd0;
            rddata_q   <= 32'd0;
            pos_q      <= 4'd0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            regwrite_q <= regwrite_d;
            rdaddr_q   <= rdaddr_d;
            rddata_q   <= rddata_d;
            pos_q      <= pos_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign RegWrite_o = regwrite_q;
    assign RDaddr_o   = rdaddr_q;
    assign RDdata_o   = rddata_q;
    assign is_pos_o   = pos_q;

    // A write-back to a register with nothing in flight is a requester bug.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n) !underflow);

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: a cycle model predicts grants,
// counters and busy flags; predicted register-file writes are queued and a
// separate monitor matches them against the registered write port.
module tb_regfile_wb_sched;

    localparam int CMAX = 3;

    logic              clk_i = 1'b0;
    logic              reset_n;
    logic [2:0]        wb_valid_i;
    logic [2:0][4:0]   wb_rd_i;
    logic [2:0][31:0]  wb_data_i;
    logic [2:0][3:0]   wb_pos_i;
    logic [2:0]        wb_ready_o;
    logic              issue_valid_i;
    logic [4:0]        issue_rd_i;
    logic              issue_ready_o;
    logic [4:0]        RSaddr_i, RTaddr_i;
    logic              rs_busy_o, rt_busy_o;
    logic              RegWrite_o;
    logic [4:0]        RDaddr_o;
    logic [31:0]       RDdata_o;
    logic [3:0]        is_pos_o;

    regfile_wb_sched #(.NREQ(3), .CNTW(2)) dut (
        .clk_i(clk_i), .reset_n(reset_n),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .wb_pos_i(wb_pos_i), .wb_ready_o(wb_ready_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .issue_ready_o(issue_ready_o),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .rs_busy_o(rs_busy_o), .rt_busy_o(rt_busy_o),
        .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
        .is_pos_o(is_pos_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  pos;
        int          cyc;
    } wb_t;

    wb_t         exp_q[$];
    wb_t         mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    int          m_cnt[32];
    int          m_last;
    logic [2:0]  obs_ready;

    bit          pend[3];
    logic [4:0]  prd[3];
    logic [31:0] pdat[3];
    logic [3:0]  ppos[3];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_last = 2;
    endfunction

    function automatic void set_req(input int p, input int rd);
        pend[p] = 1'b1;
        prd[p]  = 5'(rd);
        pdat[p] = $urandom;
        ppos[p] = 4'($urandom);
    endfunction

    // New request to some register that still has an unclaimed in-flight write.
    function automatic void refill(input int p);
        int start, r, claimed;
        if (pend[p]) return;
        start = $urandom_range(1, 31);
        for (int k = 0; k < 31; k++) begin
            r = 1 + ((start - 1 + k) % 31);
            claimed = 0;
            for (int j = 0; j < 3; j++)
                if (pend[j] && prd[j] == 5'(r)) claimed++;
            if (m_cnt[r] - claimed > 0) begin
                set_req(p, r);
                return;
            end
        end
    endfunction

    task automatic drive();
        for (int p = 0; p < 3; p++) begin
            wb_valid_i[p] = pend[p];
            wb_rd_i[p]    = prd[p];
            wb_data_i[p]  = pdat[p];
            wb_pos_i[p]   = ppos[p];
        end
    endtask

    // Predict this cycle's grant and flags, queue the expected write and
    // advance the model past the coming clock edge.
    task automatic model_eval(output int g);
        int  p;
        bit  exp_ir;
        wb_t e;
        g = -1;
        for (int k = 1; k <= 3; k++) begin
            p = (m_last + k) % 3;
            if (g < 0 && wb_valid_i[p]) g = p;
        end
        obs_ready = wb_ready_o;
        chk("wb_ready", 32'(wb_ready_o), (g >= 0) ? (32'd1 << g) : 32'd0);
        exp_ir = (issue_rd_i == 5'd0) || (m_cnt[issue_rd_i] < CMAX);
        chk("issue_ready", 32'(issue_ready_o), 32'(exp_ir));
        chk("rs_busy", 32'(rs_busy_o), 32'(m_cnt[RSaddr_i] != 0));
        chk("rt_busy", 32'(rt_busy_o), 32'(m_cnt[RTaddr_i] != 0));
        if (g >= 0) begin
            m_last = g;
            if (wb_rd_i[g] != 5'd0) begin
                e.rd = wb_rd_i[g]; e.data = wb_data_i[g]; e.pos = wb_pos_i[g]; e.cyc = cyc;
                exp_q.push_back(e);
                m_cnt[wb_rd_i[g]]--;
            end
        end
        if (issue_valid_i && exp_ir && issue_rd_i != 5'd0) m_cnt[issue_rd_i]++;
    endtask

    // One cycle: drive, evaluate at the falling edge, return at posedge+1.
    task automatic tick(output int g);
        drive();
        @(negedge clk_i);
        model_eval(g);
        @(posedge clk_i);
        #1;
        if (g >= 0) pend[g] = 1'b0;
    endtask

    // Write-port monitor: a write granted in cycle N must appear in cycle N+1.
    always @(negedge clk_i) begin
        if (reset_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
                mon_e = exp_q.pop_front();
                chk("regwrite", 32'(RegWrite_o), 32'd1);
                chk("rdaddr", 32'(RDaddr_o), 32'(mon_e.rd));
                chk("rddata", RDdata_o, mon_e.data);
                chk("is_pos", 32'(is_pos_o), 32'(mon_e.pos));
            end else begin
                chk("regwrite_idle", 32'(RegWrite_o), 32'd0);
            end
        end
    end

    logic [2:0] rr_seq[6];

    initial begin
        int g;
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        model_reset();
        for (int p = 0; p < 3; p++) begin
            pend[p] = 1'b0; prd[p] = '0; pdat[p] = '0; ppos[p] = '0;
        end

        // Reset held with every input active.
        reset_n = 1'b0;
        set_req(0, 1); set_req(1, 2); set_req(2, 3);
        drive();
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        RSaddr_i = 5'd5; RTaddr_i = 5'd5;
        #23;
        chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
        chk("rst_ready", 32'(wb_ready_o), 32'd0);
        chk("rst_rs_busy", 32'(rs_busy_o), 32'd0);
        chk("rst_rddata", RDdata_o, 32'd0);
        for (int p = 0; p < 3; p++) pend[p] = 1'b0;
        drive();
        issue_valid_i = 1'b0;
        @(posedge clk_i); #3 reset_n = 1'b1;
        @(posedge clk_i); #1;

        // Round-robin: six destinations in flight, all ports kept valid.
        issue_valid_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            issue_rd_i = 5'(i);
            tick(g);
        end
        issue_valid_i = 1'b0;
        set_req(0, 1); set_req(1, 2); set_req(2, 3);
        for (int i = 0; i < 6; i++) begin
            tick(g);
            chk("rr_seq", 32'(obs_ready), 32'(rr_seq[i]));
            if (g >= 0) refill(g);
        end

        // Scoreboard saturation and drain on rd=5.
        issue_valid_i = 1'b1; issue_rd_i = 5'd5; RSaddr_i = 5'd5;
        for (int i = 0; i < 3; i++) tick(g);
        #1;
        chk("rd5_saturated", 32'(issue_ready_o), 32'd0);
        chk("rd5_busy", 32'(rs_busy_o), 32'd1);
        tick(g);
        issue_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 5);
            tick(g);
        end
        #1;
        chk("rd5_cleared", 32'(rs_busy_o), 32'd0);

        // Same-cycle issue and write-back on rd=7.
        issue_valid_i = 1'b1; issue_rd_i = 5'd7; RTaddr_i = 5'd7;
        tick(g);
        set_req(1, 7);
        tick(g);
        chk("rd7_still_busy", 32'(rt_busy_o), 32'd1);
        issue_valid_i = 1'b0;
        set_req(0, 7);
        tick(g);

        // x0 write from port 1 is granted but never reaches the file.
        set_req(1, 0);
        pdat[1] = 32'hDEADBEEF;
        tick(g);
        chk("x0_grant", 32'(obs_ready), 32'b010);
        issue_valid_i = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            issue_rd_i = 5'(i);
            tick(g);
        end
        issue_valid_i = 1'b0;
        set_req(0, 10); set_req(1, 11); set_req(2, 12);
        tick(g);
        chk("after_x0_port2", 32'(obs_ready), 32'b100);
        for (int i = 0; i < 2; i++) tick(g);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < 3; p++) begin
                if (!pend[p] && ($urandom % 2 == 0)) begin
                    if ($urandom % 8 == 0) set_req(p, 0);
                    else refill(p);
                end
            end
            issue_valid_i = 1'($urandom % 2);
            issue_rd_i    = ($urandom % 4 == 0) ? 5'($urandom % 32) : 5'($urandom_range(0, 7));
            RSaddr_i      = 5'($urandom_range(0, 9));
            RTaddr_i      = 5'($urandom % 32);
            tick(g);
        end
        issue_valid_i = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (pend[0] || pend[1] || pend[2]) tick(g);
        end

        // Reset asserted while a write is on the port.
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        tick(g);
        issue_valid_i = 1'b0;
        set_req(0, 9);
        tick(g);
        chk("pre_reset_regwrite", 32'(RegWrite_o), 32'd1);
        #1 reset_n = 1'b0;
        for (int p = 0; p < 3; p++) set_req(p, 4);
        drive();
        #1;
        chk("midrst_regwrite", 32'(RegWrite_o), 32'd0);
        chk("midrst_rdaddr", 32'(RDaddr_o), 32'd0);
        chk("midrst_ready", 32'(wb_ready_o), 32'd0);
        for (int p = 0; p < 3; p++) pend[p] = 1'b0;
        drive();
        exp_q.delete();
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i); #3 reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            RSaddr_i = 5'(i); RTaddr_i = 5'(31 - i);
            #1;
            chk("post_rst_rs_busy", 32'(rs_busy_o), 32'd0);
            chk("post_rst_rt_busy", 32'(rt_busy_o), 32'd0);
        end
        @(posedge clk_i); #1;
        set_req(0, 0); set_req(1, 0); set_req(2, 0);
        tick(g);
        chk("post_rst_first", 32'(obs_ready), 32'b001);
        for (int i = 0; i < 5; i++) tick(g);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
